uart_rx_v2: RTL and testbench
=============================

UART_RX_V2 -- requirements
Module: uart_rx_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data bits; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, ticks per bit; must be even and at least 8.
REQ-003 SHALL have parameter DIV_WIDTH, default 16, width of baud_div.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two; used only under UART_RX_FIFO_EN.
REQ-005 SHALL have port clk, input, 1, clock.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx, input, 1, asynchronous serial line; idle high.
REQ-008 SHALL have port baud_div, input, DIV_WIDTH, oversample tick period minus one, in clk cycles.
REQ-009 SHALL have port parity_mode, input, 2, 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port stop2, input, 1, 0 one stop bit, 1 two stop bits.
REQ-011 SHALL have port data_o, output, DATA_WIDTH, received word, LSB = first bit.
REQ-012 SHALL have port parity_err_o, output, 1, parity error flag qualified by valid_o.
REQ-013 SHALL have port frame_err_o, output, 1, stop-bit error flag qualified by valid_o.
REQ-014 SHALL have port valid_o, output, 1, word available.
REQ-015 SHALL have port ready_i, input, 1, consumer accepts the word.
REQ-016 SHALL have port overrun_o, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-017 SHALL have port rx_busy, output, 1, high whenever the state is not IDLE.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-019 Tick generator SHALL emit one tick every baud_div+1 clk cycles while not IDLE.
- It SHALL restart at 0 on start detection.
- baud_div SHALL be captured at start detection and held for the whole frame.
REQ-020 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE to START on synchronized rx high-to-low.
- START to DATA after OVERSAMPLE ticks.
- DATA to PARITY, or to STOP when parity is none, after DATA_WIDTH bits.
- PARITY to STOP after one bit.
- STOP to IDLE at the mid-sample of the last stop bit, so back-to-back frames are received.
REQ-021 Each bit SHALL be taken as the majority vote of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-022 A start bit that votes 1 SHALL return the FSM to IDLE with no output and no flags.
REQ-023 Parity_err SHALL be set when the XOR of the data bits and the parity bit does not match the mode: 0 for even, 1 for odd.
REQ-024 Frame_err SHALL be set when any stop bit votes 0.
REQ-025 A completed frame SHALL write {data, parity_err, frame_err} to the output store one cycle after the final stop mid-sample.
REQ-026 valid_o SHALL stay high until a cycle with valid_o and ready_i both high; the store then advances in that same cycle.
REQ-027 If the store is full when a frame completes, that frame SHALL be discarded and overrun_o SHALL pulse for one cycle.
- Held data SHALL be unchanged.
- A simultaneous pop SHALL free space first, so no overrun occurs.
REQ-028 data_o, parity_err_o and frame_err_o SHALL be stable while valid_o is high and unaccepted.

Reset
REQ-029 On rstn low the block SHALL, asynchronously:
- enter IDLE and clear all counters, the store and the synchronizer (synchronizer to 1);
- drive data_o 0, parity_err_o 0, frame_err_o 0, valid_o 0, overrun_o 0, rx_busy 0.
REQ-030 Reset mid-frame SHALL abandon the frame; no partial word is ever presented.

Configuration
REQ-031 With macro UART_RX_FIFO_EN defined, the store SHALL be a FIFO_DEPTH-entry FIFO with first-word-fall-through output; full means FIFO_DEPTH entries.
REQ-032 Without UART_RX_FIFO_EN, the store SHALL be a single holding register; full means valid_o is high.

Verification
REQ-033 baud_div=67, 8N1, byte 0xA5, ready_i=1 -> data_o=0xA5, valid_o high for 1 cycle, both error flags 0.
REQ-034 Even parity, byte 0x03 sent with parity bit 1 -> data_o=0x03, parity_err_o=1; same byte with odd parity and parity bit 1 -> parity_err_o=0.
REQ-035 Stop bit driven 0 for byte 0x55 -> frame_err_o=1, data_o=0x55; then the next frame 0x12 is received correctly.
REQ-036 rx low pulse of 5 clk while baud_div=67 -> FSM returns to IDLE, valid_o stays 0; a 1-sample glitch at mid-bit of 0xFF -> majority vote gives 0xFF.
REQ-037 ready_i=0 with 3 frames 0x11, 0x22, 0x33 -> without FIFO, 0x11 held and two overrun pulses; with FIFO depth 8, three entries popped in order and no overrun.
REQ-038 rstn asserted mid-DATA -> all outputs 0 immediately; after release a fresh 0x3C frame is received cleanly.

Source files
------------

// File: rtl/uart_rx_v2_if.sv
// Receive-side handshake bundle for uart_rx_v2: the received word, its error
// flags and the valid/ready pair. The receiver drives through the master
// modport; the consumer uses the slave modport.
interface uart_rx_v2_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] data_o;
    logic                  parity_err_o;
    logic                  frame_err_o;
    logic                  valid_o;
    logic                  ready_i;

    modport master (
        output data_o,
        output parity_err_o,
        output frame_err_o,
        output valid_o,
        input  ready_i
    );

    modport slave (
        input  data_o,
        input  parity_err_o,
        input  frame_err_o,
        input  valid_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_v2.sv
// Oversampling UART receiver with a 3-sample majority vote per bit,
// optional parity, 1 or 2 stop bits and a valid/ready output store.
// Build option: define UART_RX_FIFO_EN to use a FIFO_DEPTH-entry
// first-word-fall-through FIFO as the store. When it is not defined, the
// store is a single holding register.
//
// state  | meaning
// IDLE   | line idle, waiting for a synchronized high-to-low edge
// START  | inside the start bit; a start bit that votes 1 is abandoned
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | sampling the parity bit (only when parity is enabled)
// STOP   | sampling stop bit(s); leaves at the mid-sample of the last one
module uart_rx_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 overrun_o,
    output logic                 rx_busy,
    uart_rx_v2_if.master         rx_if
);
    localparam int TW     = $clog2(OVERSAMPLE);
    localparam int BW     = $clog2(DATA_WIDTH);
    localparam int WORD_W = DATA_WIDTH + 2;
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_s1_q, rx_s2_q, rx_s3_q;
    logic [DIV_WIDTH-1:0]  div_q, div_cnt_q;
    logic [TW-1:0]         tick_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic                  stop_cnt_q;
    logic [1:0]            samp_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q, perr_q, ferr_q, done_q;
    logic                  par_en_q, par_odd_q, overrun_q;

    logic                  start_det, tick, vote_tick, bit_end, bit_val;
    logic                  full, valid, pop, push;
    logic [WORD_W-1:0]     word, rd_word;

    // rx_s3_q only remembers the previous synchronized value for edge detection
    assign start_det = (state_q == IDLE) && rx_s3_q && !rx_s2_q;
    assign tick      = (state_q != IDLE) && (div_cnt_q == '0);
    assign vote_tick = tick && (tick_cnt_q == T_S2);
    assign bit_end   = tick && (tick_cnt_q == T_END);
    assign bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) | (samp_q[1] & rx_s2_q);
    assign word      = {shift_q, perr_q, ferr_q};

    // Two-flop synchronizer plus edge-history flop, all idle-high
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_det) state_d = START;
            START:   if (vote_tick && bit_val) state_d = IDLE;
                     else if (bit_end)         state_d = DATA;
            DATA:    if (bit_end && bit_cnt_q == '0) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (vote_tick && !stop_cnt_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tick timer, sample capture, shift register and error accumulation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q      <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp_q     <= 2'b11;
            shift_q    <= '0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_det) begin
                // frame settings are frozen here so mid-frame changes cannot corrupt it
                div_q      <= baud_div;
                div_cnt_q  <= baud_div;
                tick_cnt_q <= '0;
                stop_cnt_q <= stop2;
                par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_odd_q  <= (parity_mode == 2'b10);
                par_q      <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
            end else if (state_q != IDLE) begin
                if (tick) begin
                    div_cnt_q  <= div_q;
                    tick_cnt_q <= (tick_cnt_q == T_END) ? '0 : tick_cnt_q + 1'b1;
                end else begin
                    div_cnt_q <= div_cnt_q - 1'b1;
                end
                if (tick && tick_cnt_q == T_S0) samp_q[0] <= rx_s2_q;
                if (tick && tick_cnt_q == T_S1) samp_q[1] <= rx_s2_q;
                if (vote_tick) begin
                    case (state_q)
                        DATA: begin
                            shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                            par_q   <= par_q ^ bit_val;
                        end
                        PARITY: perr_q <= (par_q ^ bit_val) != par_odd_q;
                        STOP: begin
                            if (!bit_val)    ferr_q <= 1'b1;
                            if (!stop_cnt_q) done_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (bit_end) begin
                    case (state_q)
                        START:   bit_cnt_q  <= BW'(DATA_WIDTH - 1);
                        DATA:    bit_cnt_q  <= bit_cnt_q - 1'b1;
                        STOP:    stop_cnt_q <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_q, rd_q;

    assign valid   = (wr_q != rd_q);
    assign full    = ((wr_q - rd_q) == (AW + 1)'(FIFO_DEPTH));
    assign pop     = valid && rx_if.ready_i;
    assign push    = done_q && (!full || pop);
    assign rd_word = valid ? mem_q[rd_q[AW-1:0]] : '0;

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // FIFO storage; unread entries are masked at the output, so no reset needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= word;
    end
`else
    logic [WORD_W-1:0] hold_q;
    logic              valid_q;

    assign valid   = valid_q;
    assign full    = valid_q;
    assign pop     = valid_q && rx_if.ready_i;
    assign push    = done_q && (!full || pop);
    assign rd_word = hold_q;

    // Single holding register; a pop in the same cycle makes room for a new word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else if (push) begin
            hold_q  <= word;
            valid_q <= 1'b1;
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end
`endif

    // Overrun pulse when a completed frame finds no room
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) overrun_q <= 1'b0;
        else       overrun_q <= done_q && !push;
    end

    assign {rx_if.data_o, rx_if.parity_err_o, rx_if.frame_err_o} = rd_word;
    assign rx_if.valid_o = valid;
    assign overrun_o     = overrun_q;
    assign rx_busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_v2.sv
// Directed plus randomized bench for uart_rx_v2. Frames are driven bit by bit;
// the expected word for each frame is computed from the sent data, parity bit
// and stop bits and compared against words popped through valid/ready.
module tb_uart_rx_v2;
    localparam int DW = 8;
    localparam int OS = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic [1:0]  parity_mode = 2'b00;
    logic        stop2 = 1'b0;
    logic        overrun_o;
    logic        rx_busy;

    uart_rx_v2_if #(.DATA_WIDTH(DW)) rx_if ();

    uart_rx_v2 #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .DIV_WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx          (rx),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .overrun_o   (overrun_o),
        .rx_busy     (rx_busy),
        .rx_if       (rx_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int vcyc = 0;
    int ovr = 0;
    logic [DW+1:0] got[$];
    logic [DW+1:0] exp_q[$];

    always @(negedge clk) begin
        if (rstn) begin
            if (rx_if.valid_o && rx_if.ready_i)
                got.push_back({rx_if.data_o, rx_if.parity_err_o, rx_if.frame_err_o});
            if (rx_if.valid_o) vcyc++;
            if (overrun_o)     ovr++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bit_cycles();
        return (int'(baud_div) + 1) * OS;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cyc(bit_cycles());
    endtask

    // data bit with a one-tick low glitch near the bit centre
    task automatic drive_glitch_one();
        int bc;
        bc = bit_cycles();
        rx = 1'b1;
        wait_cyc(bc / 2 + 3);
        rx = 1'b0;
        wait_cyc(int'(baud_div) + 1);
        rx = 1'b1;
        wait_cyc(bc - bc / 2 - 3 - (int'(baud_div) + 1));
    endtask

    // stop bit i takes value stops[i]; bad_par flips the parity bit
    task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pm, input logic s2,
                              input logic bad_par, input logic [1:0] stops, input int gap);
        logic pen, pb, pe, fe;
        parity_mode = pm;
        stop2 = s2;
        pen = (pm == 2'b01) || (pm == 2'b10);
        pb = (^d) ^ (pm == 2'b10) ^ bad_par;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (pen) drive_bit(pb);
        drive_bit(stops[0]);
        if (s2) drive_bit(stops[1]);
        rx = 1'b1;
        if (gap > 0) wait_cyc(gap);
        pe = pen && (((^d) ^ pb) != (pm == 2'b10));
        fe = !stops[0] || (s2 && !stops[1]);
        exp_q.push_back({d, pe, fe});
    endtask

    task automatic check_rx(input string tag);
        logic [DW+1:0] g, e;
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, g[DW+1:2], e[DW+1:2]);
            chk({tag, "_perr"}, g[1], e[1]);
            chk({tag, "_ferr"}, g[0], e[0]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0, o0;
        logic [DW-1:0] d;
        logic [1:0] pm, sb;
        logic s2, bp;

        rx_if.ready_i = 1'b1;
        wait_cyc(3);
        chk("rst_valid", rx_if.valid_o, 1'b0);
        chk("rst_data", rx_if.data_o, 8'h00);
        chk("rst_perr", rx_if.parity_err_o, 1'b0);
        chk("rst_ferr", rx_if.frame_err_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        rstn = 1'b1;
        wait_cyc(5);
        chk("idle_busy", rx_busy, 1'b0);

        // 8N1 0xA5 at baud_div 67, consumer always ready
        baud_div = 16'd67;
        v0 = vcyc;
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        chk("a5_valid_cycles", vcyc - v0, 1);
        check_rx("a5");

        // parity: even with wrong bit, odd with right bit
        baud_div = 16'd3;
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 2'b11, bit_cycles() + 10);
        send_frame(8'h03, 2'b10, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        check_rx("par");

        // framing error then a clean frame
        send_frame(8'h55, 2'b00, 1'b0, 1'b0, 2'b00, bit_cycles() + 10);
        send_frame(8'h12, 2'b00, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        check_rx("frame");

        // short low pulse is rejected as a false start
        baud_div = 16'd67;
        v0 = vcyc;
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(20);
        chk("glitch_busy_hi", rx_busy, 1'b1);
        wait_cyc(1500);
        chk("glitch_busy_lo", rx_busy, 1'b0);
        chk("glitch_no_valid", vcyc - v0, 0);
        chk("glitch_no_word", got.size(), 0);

        // mid-bit glitch inside 0xFF is voted away
        baud_div = 16'd3;
        parity_mode = 2'b00;
        stop2 = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            if (i == 3) drive_glitch_one();
            else        drive_bit(1'b1);
        end
        drive_bit(1'b1);
        wait_cyc(bit_cycles() + 10);
        exp_q.push_back({8'hFF, 1'b0, 1'b0});
        check_rx("vote");

        // randomized frames
        for (int k = 0; k < 10; k++) begin
            d  = DW'($urandom);
            pm = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            bp = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            baud_div = 16'($urandom_range(2, 5));
            send_frame(d, pm, s2, bp, sb, bit_cycles() + 10);
        end
        check_rx("rand");

        // back-to-back frames while the consumer stalls
        baud_div = 16'd3;
        rx_if.ready_i = 1'b0;
        o0 = ovr;
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, 0);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, 0);
        send_frame(8'h33, 2'b00, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        chk("stall_valid", rx_if.valid_o, 1'b1);
        chk("stall_head", rx_if.data_o, 8'h11);
`ifdef UART_RX_FIFO_EN
        chk("stall_overruns", ovr - o0, 0);
`else
        chk("stall_overruns", ovr - o0, 2);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
`endif
        rx_if.ready_i = 1'b1;
        wait_cyc(10);
        check_rx("stall");

        // reset in the middle of DATA with a word already held
        rx_if.ready_i = 1'b0;
        send_frame(8'h77, 2'b00, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        chk("pre_rst_valid", rx_if.valid_o, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        wait_cyc(20);
        chk("pre_rst_busy", rx_busy, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", rx_if.valid_o, 1'b0);
        chk("mid_rst_data", rx_if.data_o, 8'h00);
        chk("mid_rst_perr", rx_if.parity_err_o, 1'b0);
        chk("mid_rst_ferr", rx_if.frame_err_o, 1'b0);
        chk("mid_rst_overrun", overrun_o, 1'b0);
        chk("mid_rst_busy", rx_busy, 1'b0);
        rx = 1'b1;
        wait_cyc(5);
        rstn = 1'b1;
        got.delete();
        exp_q.delete();
        rx_if.ready_i = 1'b1;
        wait_cyc(5);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 2'b11, bit_cycles() + 10);
        check_rx("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
